// File: rtl/bg_fetch_sequencer.sv
// Background line fetch sequencer.
//
// On line_start the block reads the background colour byte, then for each of
// NCOLS tile columns reads the tile byte from the nametable and two pattern
// bytes from pattern memory. It writes one 19-bit entry per column into the
// scanline buffer. Both memories are synchronous, so read data is valid one
// cycle after the address.
//
// Ports
//   clk          pixel clock, rising edge
//   rst          asynchronous active-low reset
//   line_start   single-cycle fetch request for scanline next_yp
//   next_yp      target scanline: row = [7:3], tile_y = [2:0]
//   ntbl_addr    nametable read address (0 when unused)
//   ntbl_rdata   nametable read data
//   pmb_addr     pattern read address (0 when unused)
//   pmb_rdata    pattern read data
//   bsm_we       scanline-buffer write strobe
//   bsm_col      scanline-buffer column
//   bsm_data     {colour[2:0], pixels[15:0]}
//   cpu_req      CPU request for the VRAM port
//   cpu_gnt      CPU grant, only while idle and no fetch is starting
//   busy         fetch in progress
//   done         one-cycle pulse at the end of a fetch
//   overrun      sticky: line_start arrived while busy
//   ovr_clr      clears overrun (a simultaneous new overrun wins)
module bg_fetch_sequencer #(
   parameter int COLOR_ADDR = 960,
   parameter int NCOLS      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line_start,
   input  logic [7:0]  next_yp,
   output logic [9:0]  ntbl_addr,
   input  logic [7:0]  ntbl_rdata,
   output logic [8:0]  pmb_addr,
   input  logic [7:0]  pmb_rdata,
   output logic        bsm_we,
   output logic [4:0]  bsm_col,
   output logic [18:0] bsm_data,
   input  logic        cpu_req,
   output logic        cpu_gnt,
   output logic        busy,
   output logic        done,
   output logic        overrun,
   input  logic        ovr_clr
);

   typedef enum logic [2:0] {
      IDLE, COLOR, TILE, PAT0, PAT1, WR, DONE
   } state_t;

   localparam logic [9:0] COLOR_A  = 10'(COLOR_ADDR);
   localparam logic [4:0] LAST_COL = 5'(NCOLS - 1);

   state_t      state, state_nxt;
   logic [4:0]  col;
   logic [4:0]  row;
   logic [2:0]  tile_y;
   logic [5:0]  colour_byte;
   logic [7:0]  tile;
   logic [7:0]  byte0;
   logic [7:0]  tile_cur;
   logic [2:0]  y_eff;
   logic [2:0]  colour_sel;

   // Mirror the eight 2-bit pixels of a line when en is set.
   function automatic logic [15:0] hflip(input logic [15:0] px, input logic en);
      logic [15:0] r;
      r = px;
      if (en) begin
         for (int i = 0; i < 8; i++) begin
            r[2*(7-i) +: 2] = px[2*i +: 2];
         end
      end
      return r;
   endfunction

   // Control state: reset here forces an abort with no partial completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         col     <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && line_start) begin
            col <= '0;
         end else if (state == WR && col != LAST_COL) begin
            col <= col + 5'd1;
         end
         if (line_start && state != IDLE) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   // Data captures: only the bits that are consumed later are kept.
   always_ff @(posedge clk) begin
      if (state == IDLE && line_start) begin
         row    <= next_yp[7:3];
         tile_y <= next_yp[2:0];
      end
      // Colour byte arrives during the first TILE cycle (col is still 0).
      if (state == TILE && col == 5'd0) begin
         colour_byte <= ntbl_rdata[5:0];
      end
      if (state == PAT0) begin
         tile <= ntbl_rdata;
      end
      if (state == PAT1) begin
         byte0 <= pmb_rdata;
      end
   end

   // In PAT0 the tile byte is still on the read bus, not yet in the register.
   assign tile_cur   = (state == PAT0) ? ntbl_rdata : tile;
   assign y_eff      = tile_cur[5] ? (3'd7 - tile_y) : tile_y;
   assign colour_sel = tile[7] ? colour_byte[5:3] : colour_byte[2:0];

   always_comb begin
      state_nxt = state;
      ntbl_addr = '0;
      pmb_addr  = '0;
      bsm_we    = 1'b0;
      bsm_col   = '0;
      bsm_data  = '0;
      case (state)
         IDLE: begin
            if (line_start) state_nxt = COLOR;
         end
         COLOR: begin
            ntbl_addr = COLOR_A;
            state_nxt = TILE;
         end
         TILE: begin
            ntbl_addr = {row, col};
            state_nxt = PAT0;
         end
         PAT0: begin
            pmb_addr  = {tile_cur[4:0], y_eff, 1'b0};
            state_nxt = PAT1;
         end
         PAT1: begin
            pmb_addr  = {tile_cur[4:0], y_eff, 1'b1};
            state_nxt = WR;
         end
         WR: begin
            bsm_we    = 1'b1;
            bsm_col   = col;
            bsm_data  = {colour_sel, hflip({byte0, pmb_rdata}, tile[6])};
            state_nxt = (col == LAST_COL) ? DONE : TILE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   // rst gates the grant so it drops immediately while reset is held.
   assign cpu_gnt = rst & cpu_req & (state == IDLE) & ~line_start;

endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// Bench for bg_fetch_sequencer: memory models, a reference model that predicts
// every scanline-buffer write and done pulse from the fetch rules, and a
// monitor that compares the DUT against those predictions every cycle.
module tb_bg_fetch_sequencer;
   localparam int COLOR_ADDR = 960;
   localparam int NCOLS      = 32;
   localparam int FETCH_LEN  = 130;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        line_start = 1'b0;
   logic [7:0]  next_yp = 8'd0;
   logic [9:0]  ntbl_addr;
   logic [7:0]  ntbl_rdata;
   logic [8:0]  pmb_addr;
   logic [7:0]  pmb_rdata;
   logic        bsm_we;
   logic [4:0]  bsm_col;
   logic [18:0] bsm_data;
   logic        cpu_req = 1'b1;
   logic        cpu_gnt;
   logic        busy;
   logic        done;
   logic        overrun;
   logic        ovr_clr = 1'b0;

   logic [7:0]  ntbl_mem [0:1023];
   logic [7:0]  pmb_mem  [0:511];

   typedef struct {
      int          cyc;
      int          col;
      logic [18:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   int          exp_done[$];
   int          cyc = 0;
   int          fetch_start = -1000;
   bit          ovr_model = 1'b0;
   bit          rand_req = 1'b0;
   int          last_cyc = 0;
   logic [18:0] col0_data = '0;
   int          passed = 0;
   int          total = 0;

   bg_fetch_sequencer #(.COLOR_ADDR(COLOR_ADDR), .NCOLS(NCOLS)) dut (
      .clk(clk), .rst(rst), .line_start(line_start), .next_yp(next_yp),
      .ntbl_addr(ntbl_addr), .ntbl_rdata(ntbl_rdata),
      .pmb_addr(pmb_addr), .pmb_rdata(pmb_rdata),
      .bsm_we(bsm_we), .bsm_col(bsm_col), .bsm_data(bsm_data),
      .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .busy(busy), .done(done),
      .overrun(overrun), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ntbl_rdata <= ntbl_mem[ntbl_addr];
      pmb_rdata  <= pmb_mem[pmb_addr];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit busy_at(input int c);
      return (c >= fetch_start + 1) && (c <= fetch_start + FETCH_LEN);
   endfunction

   // Expected scanline word for column k of the given row / tile line.
   function automatic logic [18:0] ref_word(input int row, input int ty, input int k);
      logic [7:0]  t, cb, b0, b1;
      logic [15:0] pix, outp;
      logic [2:0]  clr;
      int          yv, base;
      t    = ntbl_mem[10'(row * 32 + k)];
      cb   = ntbl_mem[COLOR_ADDR];
      yv   = t[5] ? 7 - ty : ty;
      base = int'(t[4:0]) * 16 + yv * 2;
      b0   = pmb_mem[9'(base)];
      b1   = pmb_mem[9'(base + 1)];
      pix  = {b0, b1};
      outp = pix;
      if (t[6]) begin
         for (int i = 0; i < 8; i++) outp[2*i +: 2] = pix[2*(7-i) +: 2];
      end
      clr = t[7] ? cb[5:3] : cb[2:0];
      return {clr, outp};
   endfunction

   // Reference model: accepted requests push their whole expected line.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_start <= -1000;
         ovr_model   <= 1'b0;
         exp_wr.delete();
         exp_done.delete();
      end else begin
         if (line_start && !busy_at(cyc)) begin
            wr_t w;
            fetch_start <= cyc;
            for (int k = 0; k < NCOLS; k++) begin
               w.cyc  = cyc + 5 + 4 * k;
               w.col  = k;
               w.data = ref_word(int'(next_yp[7:3]), int'(next_yp[2:0]), k);
               exp_wr.push_back(w);
            end
            exp_done.push_back(cyc + FETCH_LEN);
         end
         if (line_start && busy_at(cyc)) ovr_model <= 1'b1;
         else if (ovr_clr) ovr_model <= 1'b0;
      end
   end

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (bsm_we) begin
            if (exp_wr.size() == 0) begin
               check("unexpected_write", 64'(bsm_col), 64'hFFFF);
            end else begin
               wr_t w;
               w = exp_wr.pop_front();
               check("wr_cycle", 64'(cyc), 64'(w.cyc));
               check("wr_col", 64'(bsm_col), 64'(w.col));
               check("wr_data", 64'(bsm_data), 64'(w.data));
               if (bsm_col == 5'd0) col0_data = bsm_data;
            end
         end
         if (done) begin
            if (exp_done.size() == 0) check("unexpected_done", 64'(cyc), 64'hFFFF);
            else check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
         end
         check("busy", 64'(busy), 64'(busy_at(cyc)));
         check("cpu_gnt", 64'(cpu_gnt), 64'(cpu_req && !busy_at(cyc) && !line_start));
         check("overrun", 64'(overrun), 64'(ovr_model));
         if (!busy_at(cyc)) check("idle_addr", {ntbl_addr, pmb_addr}, 64'd0);
      end
   end

   // cpu_req: held high for directed phases, random during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cpu_req = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic step(input bit ls, input logic [7:0] yp, input bit clr);
      @(posedge clk);
      #1;
      line_start = ls;
      next_yp    = yp;
      ovr_clr    = clr;
      last_cyc   = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, next_yp, 1'b0);
   endtask

   task automatic rand_gap(input int n);
      repeat (n) step($urandom_range(0, 39) == 0, 8'($urandom), $urandom_range(0, 19) == 0);
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < 1024; i++) ntbl_mem[i] = 8'($urandom);
      for (int i = 0; i < 512; i++) pmb_mem[i] = 8'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {bsm_we, done, busy, overrun, cpu_gnt}, 64'd0);
      check({tag, "_bus"}, {ntbl_addr, pmb_addr, bsm_col, bsm_data}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: still running at time %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      randomize_mem();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_init");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Basic fetch, requested on the first edge after reset release.
      ntbl_mem[COLOR_ADDR] = 8'h0A;
      ntbl_mem[96]         = 8'h81;
      pmb_mem[9'h018]      = 8'hE4;
      pmb_mem[9'h019]      = 8'h1B;
      step(1'b1, 8'd28, 1'b0);
      idle(135);
      check("basic_col0", 64'(col0_data), 64'h1E41B);

      // Vertical and horizontal flip.
      ntbl_mem[96]    = 8'h61;
      pmb_mem[9'h016] = 8'h12;
      pmb_mem[9'h017] = 8'h34;
      step(1'b1, 8'd28, 1'b0);
      idle(3);
      @(negedge clk);
      check("flip_pmb0", 64'(pmb_addr), 64'h016);
      idle(1);
      @(negedge clk);
      check("flip_pmb1", 64'(pmb_addr), 64'h017);
      idle(135);
      check("flip_col0", 64'(col0_data), 64'h21C84);

      // Overrun: a second request mid-fetch is ignored and flagged.
      step(1'b1, 8'd77, 1'b0);
      c = last_cyc;
      idle(49);
      step(1'b1, 8'd200, 1'b0);
      step(1'b0, 8'd200, 1'b0);
      @(negedge clk);
      check("overrun_set", 64'(overrun), 64'd1);
      idle(c + 199 - last_cyc);
      step(1'b0, 8'd0, 1'b1);
      step(1'b0, 8'd0, 1'b0);
      @(negedge clk);
      check("overrun_clr", 64'(overrun), 64'd0);

      // Set and clear in the same cycle: set wins.
      step(1'b1, 8'd250, 1'b0);
      idle(9);
      step(1'b1, 8'd5, 1'b1);
      step(1'b0, 8'd5, 1'b0);
      @(negedge clk);
      check("overrun_set_wins", 64'(overrun), 64'd1);
      idle(130);
      step(1'b0, 8'd0, 1'b1);
      idle(2);

      // Random phase; the first two lines land on rows 30 and 31.
      rand_req = 1'b1;
      for (int it = 0; it < 10; it++) begin
         randomize_mem();
         if (it < 2) step(1'b1, {5'(30 + it), 3'($urandom)}, 1'b0);
         else step(1'b1, 8'($urandom), 1'b0);
         rand_gap(140);
         idle(135);
      end
      rand_req = 1'b0;

      // Reset mid-fetch, then a complete fetch after release.
      step(1'b1, 8'd99, 1'b0);
      c = last_cyc;
      idle(49);
      step(1'b1, 8'd3, 1'b0);
      idle(c + 69 - last_cyc);
      @(posedge clk);
      #1;
      rst = 1'b0;
      line_start = 1'b0;
      #1;
      check_all_zero("reset_mid");
      idle(3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      col0_data = '0;
      step(1'b1, 8'd246, 1'b0);
      idle(140);
      check("post_reset_col0", 64'(col0_data), 64'(ref_word(30, 6, 0)));

      check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      check("done_queue_empty", 64'(exp_done.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
